// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, instruction register
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        misalign,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t      state, state_nx;
    logic [31:0] pc_q, pc_nx;
    logic [31:0] instr_q, instr_nx;
    logic [31:0] instret_q, instret_nx;
    logic        valid_q, valid_nx;
    logic        misalign_q, misalign_nx;
    logic        bad_target;

    assign bad_target = PCSrc && (PCTarget[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instret_q  <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nx;
            pc_q       <= pc_nx;
            instr_q    <= instr_nx;
            instret_q  <= instret_nx;
            valid_q    <= valid_nx;
            misalign_q <= misalign_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc_q;
        instr_nx    = instr_q;
        instret_nx  = instret_q;
        valid_nx    = valid_q;
        misalign_nx = misalign_q;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_nx = imem_rdata;
                    valid_nx = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    instret_nx = instret_q + 32'd1;
                    valid_nx   = 1'b0;
                    // A misaligned redirect still retires but freezes the PC for inspection.
                    if (bad_target) begin
                        misalign_nx = 1'b1;
                        state_nx    = HALT;
                    end else begin
                        pc_nx    = PCSrc ? PCTarget : PCPlus4;
                        state_nx = FETCH;
                    end
                end
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign misalign    = misalign_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a cycle-level model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'd0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        misalign;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_instret;
    logic        m_misalign;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .instr_valid(instr_valid), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .misalign(misalign), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_instr    = NOP_INSTR;
        m_instret  = 32'd0;
        m_misalign = 1'b0;
    endtask

    task automatic check_exec_view(input string tag);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, ".req"}, {31'd0, imem_req}, 32'd0);
        check({tag, ".instr"}, Instr, m_instr);
        check({tag, ".pc"}, PC, m_pc);
        check({tag, ".op"}, {25'd0, op}, {25'd0, m_instr[6:0]});
        check({tag, ".funct3"}, {29'd0, funct3}, {29'd0, m_instr[14:12]});
        check({tag, ".f7b5"}, {31'd0, funct7b5}, {31'd0, m_instr[30]});
        check({tag, ".pcplus4"}, PCPlus4, m_pc + 32'd4);
    endtask

    // Called at a negedge with the DUT in FETCH; returns at a negedge after retire.
    task automatic run_instr(input int wait_n, input int stall_n, input logic src,
                             input logic [31:0] tgt, input logic [31:0] word);
        for (int i = 0; i < wait_n; i++) begin
            check("fetch.req", {31'd0, imem_req}, 32'd1);
            check("fetch.addr", imem_addr, m_pc);
            imem_ack = 1'b0;
            PCSrc    = 1'($urandom);
            PCTarget = $urandom;
            @(negedge clk);
        end
        check("fetch.req", {31'd0, imem_req}, 32'd1);
        check("fetch.addr", imem_addr, m_pc);
        check("fetch.valid", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        m_instr = word;
        for (int i = 0; i < stall_n; i++) begin
            check_exec_view("stall");
            stall      = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            PCSrc      = 1'($urandom);
            PCTarget   = $urandom;
            @(negedge clk);
        end
        check_exec_view("exec");
        imem_ack = 1'b0;
        stall    = 1'b0;
        PCSrc    = src;
        PCTarget = tgt;
        @(negedge clk);
        m_instret = m_instret + 32'd1;
        if (src && (tgt % 4 != 0))
            m_misalign = 1'b1;
        else
            m_pc = src ? tgt : m_pc + 32'd4;
        PCSrc    = 1'($urandom);
        PCTarget = $urandom;
        check("retire.instret", instret, m_instret);
        check("retire.valid", {31'd0, instr_valid}, 32'd0);
        check("retire.misalign", {31'd0, misalign}, {31'd0, m_misalign});
        check("retire.pc", PC, m_pc);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.req", {31'd0, imem_req}, 32'd0);
        check("rst.pc", PC, RESET_PC);
        check("rst.instr", Instr, NOP_INSTR);
        check("rst.valid", {31'd0, instr_valid}, 32'd0);
        check("rst.misalign", {31'd0, misalign}, 32'd0);
        check("rst.instret", instret, 32'd0);

        // Release with a stray ack during the idle cycle; it must be ignored.
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1 check("idle.req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("idle.instr", Instr, NOP_INSTR);
        imem_ack = 1'b0;

        run_instr(0, 0, 1'b0, 32'd0, 32'h0050_0093);
        check("seq.op", {25'd0, m_instr[6:0]}, 32'h13);
        check("seq.addr", imem_addr, 32'h4);
        run_instr(3, 2, 1'b0, 32'd0, $urandom);
        run_instr(1, 0, 1'b1, 32'h0000_0100, $urandom);
        check("redir.addr", imem_addr, 32'h100);
        run_instr(0, 1, 1'b0, 32'd0, 32'h4020_8233);
        check("redir.f7b5", {31'd0, funct7b5}, 32'd1);

        for (int n = 0; n < 25; n++)
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);

        run_instr(0, 0, 1'b1, 32'hFFFF_FFFC, $urandom);
        run_instr(1, 2, 1'b0, 32'd0, $urandom);
        check("wrap.addr", imem_addr, 32'h0);

        run_instr(2, 1, 1'b1, 32'h0000_0102, $urandom);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'($urandom);
            stall    = 1'($urandom);
            @(negedge clk);
            check("halt.req", {31'd0, imem_req}, 32'd0);
            check("halt.valid", {31'd0, instr_valid}, 32'd0);
            check("halt.misalign", {31'd0, misalign}, 32'd1);
            check("halt.pc", PC, m_pc);
            check("halt.instret", instret, m_instret);
            check("halt.instr", Instr, m_instr);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;

        // Reset out of HALT, then reset again mid-fetch.
        rst_n = 1'b0;
        #1 check("rst2.misalign", {31'd0, misalign}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_instr(0, 0, 1'b0, 32'd0, $urandom);
        run_instr(2, 0, 1'b1, 32'h0000_0040, $urandom);
        check("mid.req", {31'd0, imem_req}, 32'd1);
        check("mid.addr", imem_addr, 32'h40);
        rst_n = 1'b0;
        #1;
        check("mid.req0", {31'd0, imem_req}, 32'd0);
        check("mid.pc", PC, RESET_PC);
        check("mid.instret", instret, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mid.late_ack", Instr, NOP_INSTR);
        check("mid.valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b0;
        run_instr(1, 0, 1'b0, 32'd0, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
